mem_access_stage: RTL and testbench

MEM_ACCESS_STAGE -- requirements
Module: mem_access_stage

---
 rtl/mem_access_stage.sv | 269 ++++++++++++++++++++++++++
 tb/tb_mem_access_stage.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage: issues data-memory transfers for loads and
// stores, stalls upstream while a transfer is outstanding, and fills the
// MEM/WB register with the result, alignment errors or bus-timeout errors.
module mem_access_stage #(
  parameter int ACK_TIMEOUT = 255
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        In_Valid,
  input  logic        Flush,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [1:0]  MemSize,
  input  logic        MemSigned,
  input  logic        RegWrite,
  input  logic [4:0]  WriteReg,
  input  logic [1:0]  MemToReg,
  input  logic [31:0] ALUResult,
  input  logic [31:0] WriteData,
  input  logic [31:0] PC,
  output logic        Stall,
  output logic        DMem_Req,
  output logic        DMem_We,
  output logic [31:0] DMem_Addr,
  output logic [31:0] DMem_WData,
  output logic [3:0]  DMem_BE,
  input  logic [31:0] DMem_RData,
  input  logic        DMem_Ack,
  output logic        WB_Valid,
  output logic        WB_RegWrite,
  output logic [4:0]  WB_WriteReg,
  output logic [1:0]  WB_MemToReg,
  output logic [31:0] WB_ALUResult,
  output logic [31:0] WB_ReadData,
  output logic [31:0] WB_PC,
  output logic        MisalignErr,
  output logic        BusErr
);

  localparam logic StIdle   = 1'b0;
  localparam logic StAccess = 1'b1;

  // The counter only ever holds 0 .. ACK_TIMEOUT-1; the last value is the
  // one on which a missing ack turns into a timeout.
  localparam int CntW = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT);
  localparam logic [CntW-1:0] CntLast = CntW'(ACK_TIMEOUT - 1);

  logic            state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            kill_q, kill_d;
  logic            memRead_q, memRead_d;
  logic            memWrite_q, memWrite_d;
  logic [1:0]      memSize_q, memSize_d;
  logic            memSigned_q, memSigned_d;
  logic            regWrite_q, regWrite_d;
  logic [4:0]      writeReg_q, writeReg_d;
  logic [1:0]      memToReg_q, memToReg_d;
  logic [31:0]     aluResult_q, aluResult_d;
  logic [31:0]     wData_q, wData_d;
  logic [3:0]      be_q, be_d;
  logic [31:0]     pc_q, pc_d;

  logic            wbValid_q, wbValid_d;
  logic            wbRegWrite_q, wbRegWrite_d;
  logic [4:0]      wbWriteReg_q, wbWriteReg_d;
  logic [1:0]      wbMemToReg_q, wbMemToReg_d;
  logic [31:0]     wbAluResult_q, wbAluResult_d;
  logic [31:0]     wbReadData_q, wbReadData_d;
  logic [31:0]     wbPc_q, wbPc_d;
  logic            misalignErr_q, misalignErr_d;
  logic            busErr_q, busErr_d;

  logic        inHalf, inByte, inMemOp, inMisaligned;
  logic [3:0]  inBe;
  logic [31:0] inWData;
  logic [7:0]  laneByte;
  logic [15:0] laneHalf;
  logic [31:0] loadData;
  logic        isLoad;
  logic        killNow;

  // Decode the incoming instruction: alignment check and store lane encoding.
  always_comb begin
    inHalf       = (MemSize == 2'b01);
    inByte       = (MemSize == 2'b10);
    inMemOp      = MemRead | MemWrite;
    inMisaligned = inMemOp & ((inHalf & ALUResult[0]) |
                              (!inHalf & !inByte & (ALUResult[1:0] != 2'b00)));
    inBe         = 4'b1111;
    inWData      = WriteData;
    if (MemWrite) begin
      if (inByte) begin
        inBe    = 4'b0001 << ALUResult[1:0];
        inWData = {4{WriteData[7:0]}};
      end else if (inHalf) begin
        inBe    = ALUResult[1] ? 4'b1100 : 4'b0011;
        inWData = {2{WriteData[15:0]}};
      end
    end
  end

  // Pick the addressed lane out of the read word and extend it.
  always_comb begin
    case (aluResult_q[1:0])
      2'b00:   laneByte = DMem_RData[7:0];
      2'b01:   laneByte = DMem_RData[15:8];
      2'b10:   laneByte = DMem_RData[23:16];
      default: laneByte = DMem_RData[31:24];
    endcase
    laneHalf = aluResult_q[1] ? DMem_RData[31:16] : DMem_RData[15:0];
    if (memSize_q == 2'b10) begin
      loadData = {{24{memSigned_q & laneByte[7]}}, laneByte};
    end else if (memSize_q == 2'b01) begin
      loadData = {{16{memSigned_q & laneHalf[15]}}, laneHalf};
    end else begin
      loadData = DMem_RData;
    end
  end

  // Next-state logic: accept in IDLE, wait for ack or timeout in ACCESS.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    kill_d        = kill_q;
    memRead_d     = memRead_q;
    memWrite_d    = memWrite_q;
    memSize_d     = memSize_q;
    memSigned_d   = memSigned_q;
    regWrite_d    = regWrite_q;
    writeReg_d    = writeReg_q;
    memToReg_d    = memToReg_q;
    aluResult_d   = aluResult_q;
    wData_d       = wData_q;
    be_d          = be_q;
    pc_d          = pc_q;
    wbValid_d     = 1'b0;
    wbRegWrite_d  = 1'b0;
    wbWriteReg_d  = wbWriteReg_q;
    wbMemToReg_d  = wbMemToReg_q;
    wbAluResult_d = wbAluResult_q;
    wbReadData_d  = wbReadData_q;
    wbPc_d        = wbPc_q;
    misalignErr_d = 1'b0;
    busErr_d      = 1'b0;
    isLoad        = memRead_q & ~memWrite_q;
    killNow       = kill_q | Flush;

    if (state_q == StIdle) begin
      if (In_Valid && !Flush) begin
        wbWriteReg_d  = WriteReg;
        wbMemToReg_d  = MemToReg;
        wbAluResult_d = ALUResult;
        wbReadData_d  = 32'h0;
        wbPc_d        = PC;
        if (!inMemOp) begin
          wbValid_d    = 1'b1;
          wbRegWrite_d = RegWrite;
        end else if (inMisaligned) begin
          wbValid_d     = 1'b1;
          misalignErr_d = 1'b1;
        end else begin
          state_d     = StAccess;
          cnt_d       = '0;
          kill_d      = 1'b0;
          memRead_d   = MemRead;
          memWrite_d  = MemWrite;
          memSize_d   = MemSize;
          memSigned_d = MemSigned;
          regWrite_d  = RegWrite;
          writeReg_d  = WriteReg;
          memToReg_d  = MemToReg;
          aluResult_d = ALUResult;
          wData_d     = inWData;
          be_d        = inBe;
          pc_d        = PC;
        end
      end
    end else begin
      kill_d = killNow;
      if (DMem_Ack || (cnt_q == CntLast)) begin
        state_d       = StIdle;
        wbValid_d     = ~killNow;
        wbWriteReg_d  = writeReg_q;
        wbMemToReg_d  = memToReg_q;
        wbAluResult_d = aluResult_q;
        wbPc_d        = pc_q;
        if (DMem_Ack) begin
          wbRegWrite_d = regWrite_q & ~killNow;
          wbReadData_d = isLoad ? loadData : 32'h0;
        end else begin
          busErr_d     = 1'b1;
          wbReadData_d = 32'h0;
        end
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // State and pipeline registers, cleared asynchronously by reset.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q       <= StIdle;
      cnt_q         <= '0;
      kill_q        <= 1'b0;
      memRead_q     <= 1'b0;
      memWrite_q    <= 1'b0;
      memSize_q     <= 2'b00;
      memSigned_q   <= 1'b0;
      regWrite_q    <= 1'b0;
      writeReg_q    <= 5'd0;
      memToReg_q    <= 2'b00;
      aluResult_q   <= 32'h0;
      wData_q       <= 32'h0;
      be_q          <= 4'h0;
      pc_q          <= 32'h0;
      wbValid_q     <= 1'b0;
      wbRegWrite_q  <= 1'b0;
      wbWriteReg_q  <= 5'd0;
      wbMemToReg_q  <= 2'b00;
      wbAluResult_q <= 32'h0;
      wbReadData_q  <= 32'h0;
      wbPc_q        <= 32'h0;
      misalignErr_q <= 1'b0;
      busErr_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      kill_q        <= kill_d;
      memRead_q     <= memRead_d;
      memWrite_q    <= memWrite_d;
      memSize_q     <= memSize_d;
      memSigned_q   <= memSigned_d;
      regWrite_q    <= regWrite_d;
      writeReg_q    <= writeReg_d;
      memToReg_q    <= memToReg_d;
      aluResult_q   <= aluResult_d;
      wData_q       <= wData_d;
      be_q          <= be_d;
      pc_q          <= pc_d;
      wbValid_q     <= wbValid_d;
      wbRegWrite_q  <= wbRegWrite_d;
      wbWriteReg_q  <= wbWriteReg_d;
      wbMemToReg_q  <= wbMemToReg_d;
      wbAluResult_q <= wbAluResult_d;
      wbReadData_q  <= wbReadData_d;
      wbPc_q        <= wbPc_d;
      misalignErr_q <= misalignErr_d;
      busErr_q      <= busErr_d;
    end
  end

  assign Stall        = (state_q == StAccess);
  assign DMem_Req     = (state_q == StAccess);
  assign DMem_We      = (state_q == StAccess) & memWrite_q;
  assign DMem_Addr    = {aluResult_q[31:2], 2'b00};
  assign DMem_WData   = wData_q;
  assign DMem_BE      = be_q;
  assign WB_Valid     = wbValid_q;
  assign WB_RegWrite  = wbRegWrite_q;
  assign WB_WriteReg  = wbWriteReg_q;
  assign WB_MemToReg  = wbMemToReg_q;
  assign WB_ALUResult = wbAluResult_q;
  assign WB_ReadData  = wbReadData_q;
  assign WB_PC        = wbPc_q;
  assign MisalignErr  = misalignErr_q;
  assign BusErr       = busErr_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Testbench for mem_access_stage: directed and randomized instructions
// checked against a byte-level reference model of loads and stores.
module tb_mem_access_stage;

  localparam int AckTimeout = 4;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [1:0]  size;
    logic        sgn;
    logic        rw;
    logic [4:0]  wreg;
    logic [1:0]  m2r;
    logic [31:0] alu;
    logic [31:0] wdata;
    logic [31:0] pc;
  } instr_t;

  logic        Clk = 1'b0;
  logic        Rst;
  logic        In_Valid, Flush, MemRead, MemWrite, MemSigned, RegWrite;
  logic [1:0]  MemSize, MemToReg;
  logic [4:0]  WriteReg;
  logic [31:0] ALUResult, WriteData, PC;
  logic        Stall, DMem_Req, DMem_We, DMem_Ack;
  logic [31:0] DMem_Addr, DMem_WData, DMem_RData;
  logic [3:0]  DMem_BE;
  logic        WB_Valid, WB_RegWrite, MisalignErr, BusErr;
  logic [4:0]  WB_WriteReg;
  logic [1:0]  WB_MemToReg;
  logic [31:0] WB_ALUResult, WB_ReadData, WB_PC;

  int errors = 0;
  int checks = 0;

  mem_access_stage #(.ACK_TIMEOUT(AckTimeout)) dut (
    .Clk(Clk), .Rst(Rst), .In_Valid(In_Valid), .Flush(Flush),
    .MemRead(MemRead), .MemWrite(MemWrite), .MemSize(MemSize),
    .MemSigned(MemSigned), .RegWrite(RegWrite), .WriteReg(WriteReg),
    .MemToReg(MemToReg), .ALUResult(ALUResult), .WriteData(WriteData),
    .PC(PC), .Stall(Stall), .DMem_Req(DMem_Req), .DMem_We(DMem_We),
    .DMem_Addr(DMem_Addr), .DMem_WData(DMem_WData), .DMem_BE(DMem_BE),
    .DMem_RData(DMem_RData), .DMem_Ack(DMem_Ack), .WB_Valid(WB_Valid),
    .WB_RegWrite(WB_RegWrite), .WB_WriteReg(WB_WriteReg),
    .WB_MemToReg(WB_MemToReg), .WB_ALUResult(WB_ALUResult),
    .WB_ReadData(WB_ReadData), .WB_PC(WB_PC),
    .MisalignErr(MisalignErr), .BusErr(BusErr)
  );

  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input instr_t ins, input logic valid, input logic flush);
    In_Valid  = valid;
    Flush     = flush;
    MemRead   = ins.rd;
    MemWrite  = ins.wr;
    MemSize   = ins.size;
    MemSigned = ins.sgn;
    RegWrite  = ins.rw;
    WriteReg  = ins.wreg;
    MemToReg  = ins.m2r;
    ALUResult = ins.alu;
    WriteData = ins.wdata;
    PC        = ins.pc;
  endtask

  // Access width in bytes; size code 3 behaves as a word.
  function automatic int accBytes(input instr_t ins);
    if (ins.size == 2'd1) return 2;
    if (ins.size == 2'd2) return 1;
    return 4;
  endfunction

  function automatic bit isMisaligned(input instr_t ins);
    if (!(ins.rd || ins.wr)) return 0;
    return (ins.alu % accBytes(ins)) != 0;
  endfunction

  function automatic logic [3:0] expBe(input instr_t ins);
    int n = accBytes(ins);
    int off = ins.alu % 4;
    if (!ins.wr) return 4'hF;
    return 4'(((1 << n) - 1) << off);
  endfunction

  function automatic logic [31:0] expWData(input instr_t ins);
    int n = accBytes(ins);
    if (n == 1) return (ins.wdata & 32'hFF) * 32'h01010101;
    if (n == 2) return (ins.wdata & 32'hFFFF) * 32'h00010001;
    return ins.wdata;
  endfunction

  function automatic logic [31:0] expRead(input instr_t ins, input logic [31:0] rdata);
    int n = accBytes(ins);
    int off = ins.alu % 4;
    logic [31:0] mask, v;
    if (ins.wr) return 32'h0;
    if (n == 4) return rdata;
    mask = (32'h1 << (8 * n)) - 1;
    v = (rdata >> (8 * off)) & mask;
    if (ins.sgn && (v > (mask >> 1))) v = v | ~mask;
    return v;
  endfunction

  function automatic instr_t randInstr();
    instr_t r;
    int kind = $urandom_range(0, 3);
    r.rd    = (kind == 1) || (kind == 3);
    r.wr    = (kind == 2) || (kind == 3);
    r.size  = 2'($urandom_range(0, 3));
    r.sgn   = 1'($urandom_range(0, 1));
    r.rw    = 1'($urandom_range(0, 1));
    r.wreg  = 5'($urandom_range(0, 31));
    r.m2r   = 2'($urandom_range(0, 3));
    r.alu   = $urandom;
    r.wdata = $urandom;
    r.pc    = $urandom;
    return r;
  endfunction

  function automatic instr_t mkInstr(input logic rd, input logic wr, input logic [1:0] size,
                                     input logic sgn, input logic rw, input logic [4:0] wreg,
                                     input logic [31:0] alu, input logic [31:0] wdata);
    instr_t r;
    r.rd = rd; r.wr = wr; r.size = size; r.sgn = sgn; r.rw = rw; r.wreg = wreg;
    r.m2r = 2'd1; r.alu = alu; r.wdata = wdata; r.pc = 32'h0000_4000 + alu;
    return r;
  endfunction

  // One full instruction: present it, follow the transfer, check the result.
  task automatic runOp(input instr_t ins, input int waits, input logic [31:0] rdata, input string tag);
    applyStimulus(ins, 1'b1, 1'b0);
    checkOutput({tag, ".stallPre"}, Stall, 0);
    tick();
    In_Valid = 1'b0;
    if (!(ins.rd || ins.wr)) begin
      checkOutput({tag, ".stall"}, Stall, 0);
      checkOutput({tag, ".wbValid"}, WB_Valid, 1);
      checkOutput({tag, ".wbRegWrite"}, WB_RegWrite, ins.rw);
      checkOutput({tag, ".wbReg"}, WB_WriteReg, ins.wreg);
      checkOutput({tag, ".wbAlu"}, WB_ALUResult, ins.alu);
      checkOutput({tag, ".wbPc"}, WB_PC, ins.pc);
      checkOutput({tag, ".wbM2r"}, WB_MemToReg, ins.m2r);
      checkOutput({tag, ".wbRdata"}, WB_ReadData, 0);
    end else if (isMisaligned(ins)) begin
      checkOutput({tag, ".misReq"}, DMem_Req, 0);
      checkOutput({tag, ".misStall"}, Stall, 0);
      checkOutput({tag, ".misErr"}, MisalignErr, 1);
      checkOutput({tag, ".misValid"}, WB_Valid, 1);
      checkOutput({tag, ".misRegWrite"}, WB_RegWrite, 0);
      tick();
      checkOutput({tag, ".misErrPulse"}, MisalignErr, 0);
    end else begin
      for (int i = 0; i <= waits; i++) begin
        checkOutput({tag, ".req"}, DMem_Req, 1);
        checkOutput({tag, ".stall"}, Stall, 1);
        checkOutput({tag, ".addr"}, DMem_Addr, ins.alu & 32'hFFFF_FFFC);
        checkOutput({tag, ".be"}, DMem_BE, expBe(ins));
        checkOutput({tag, ".we"}, DMem_We, ins.wr);
        if (ins.wr) checkOutput({tag, ".wdata"}, DMem_WData, expWData(ins));
        checkOutput({tag, ".bubble"}, WB_Valid, 0);
        if (i == waits) begin
          DMem_Ack   = 1'b1;
          DMem_RData = rdata;
        end
        tick();
      end
      DMem_Ack   = 1'b0;
      DMem_RData = $urandom;
      checkOutput({tag, ".doneStall"}, Stall, 0);
      checkOutput({tag, ".doneReq"}, DMem_Req, 0);
      checkOutput({tag, ".busErr"}, BusErr, 0);
      checkOutput({tag, ".wbValid"}, WB_Valid, 1);
      checkOutput({tag, ".wbRegWrite"}, WB_RegWrite, ins.rw);
      checkOutput({tag, ".wbReg"}, WB_WriteReg, ins.wreg);
      checkOutput({tag, ".wbAlu"}, WB_ALUResult, ins.alu);
      checkOutput({tag, ".wbPc"}, WB_PC, ins.pc);
      checkOutput({tag, ".wbM2r"}, WB_MemToReg, ins.m2r);
      checkOutput({tag, ".wbRdata"}, WB_ReadData, expRead(ins, rdata));
    end
  endtask

  initial begin
    instr_t ins, alu2;
    Rst = 1'b0;
    DMem_Ack = 1'b0;
    DMem_RData = 32'h0;
    applyStimulus(mkInstr(0, 0, 0, 0, 0, 0, 0, 0), 1'b0, 1'b0);

    // Reset state
    #1;
    checkOutput("rst.stall", Stall, 0);
    checkOutput("rst.req", DMem_Req, 0);
    checkOutput("rst.wbValid", WB_Valid, 0);
    checkOutput("rst.be", DMem_BE, 0);
    checkOutput("rst.busErr", BusErr, 0);
    #2 Rst = 1'b1;
    tick();

    // ALU op passes through in one cycle
    runOp(mkInstr(0, 0, 0, 0, 1, 5'd5, 32'h0000_1234, 0), 0, 0, "aluOp");
    tick();

    // Signed byte load at 0x103, ack on the fourth access cycle
    runOp(mkInstr(1, 0, 2'b10, 1, 1, 5'd7, 32'h0000_0103, 0), 3, 32'h80FF_0011, "ldByte");
    tick();

    // Half store at 0x202
    runOp(mkInstr(0, 1, 2'b01, 0, 0, 5'd0, 32'h0000_0202, 32'hABCD_1234), 1, 0, "stHalf");
    tick();

    // Misaligned word load
    runOp(mkInstr(1, 0, 2'b00, 0, 1, 5'd9, 32'h0000_0301, 0), 0, 0, "ldMis");

    // Flush in IDLE produces a bubble
    applyStimulus(mkInstr(0, 0, 0, 0, 1, 5'd3, 32'h55, 0), 1'b1, 1'b1);
    tick();
    Flush = 1'b0; In_Valid = 1'b0;
    checkOutput("flushIdle.wbValid", WB_Valid, 0);
    checkOutput("flushIdle.wbRegWrite", WB_RegWrite, 0);

    // Timeout: no ack, request held for AckTimeout cycles
    applyStimulus(mkInstr(1, 0, 2'b00, 0, 1, 5'd4, 32'h0000_0400, 0), 1'b1, 1'b0);
    tick();
    In_Valid = 1'b0;
    for (int i = 0; i < AckTimeout; i++) begin
      checkOutput("timeout.req", DMem_Req, 1);
      checkOutput("timeout.noErr", BusErr, 0);
      tick();
    end
    checkOutput("timeout.reqDrop", DMem_Req, 0);
    checkOutput("timeout.busErr", BusErr, 1);
    checkOutput("timeout.stall", Stall, 0);
    checkOutput("timeout.wbValid", WB_Valid, 1);
    checkOutput("timeout.wbRegWrite", WB_RegWrite, 0);
    tick();
    checkOutput("timeout.errPulse", BusErr, 0);

    // Flush during ACCESS kills the writeback but the transfer completes
    applyStimulus(mkInstr(1, 0, 2'b00, 0, 1, 5'd6, 32'h0000_0500, 0), 1'b1, 1'b0);
    tick();
    In_Valid = 1'b0; Flush = 1'b1;
    tick();
    Flush = 1'b0;
    checkOutput("flushAcc.req", DMem_Req, 1);
    DMem_Ack = 1'b1;
    tick();
    DMem_Ack = 1'b0;
    checkOutput("flushAcc.req0", DMem_Req, 0);
    checkOutput("flushAcc.wbValid", WB_Valid, 0);
    checkOutput("flushAcc.wbRegWrite", WB_RegWrite, 0);

    // Input presented on the ack edge is taken on the following edge
    ins  = mkInstr(1, 0, 2'b00, 0, 1, 5'd11, 32'h0000_0600, 0);
    alu2 = mkInstr(0, 0, 0, 0, 1, 5'd12, 32'h0BAD_F00D, 0);
    applyStimulus(ins, 1'b1, 1'b0);
    tick();
    applyStimulus(alu2, 1'b1, 1'b0);
    DMem_Ack = 1'b1; DMem_RData = 32'h1357_9BDF;
    tick();
    DMem_Ack = 1'b0;
    checkOutput("ackEdge.wbReg", WB_WriteReg, 11);
    checkOutput("ackEdge.wbRdata", WB_ReadData, 32'h1357_9BDF);
    checkOutput("ackEdge.stall", Stall, 0);
    tick();
    In_Valid = 1'b0;
    checkOutput("nextOp.wbAlu", WB_ALUResult, 32'h0BAD_F00D);
    checkOutput("nextOp.wbValid", WB_Valid, 1);

    // Asynchronous reset in the middle of an access
    applyStimulus(mkInstr(1, 0, 2'b00, 0, 1, 5'd8, 32'h0000_0700, 0), 1'b1, 1'b0);
    tick();
    In_Valid = 1'b0;
    checkOutput("rstAcc.reqBefore", DMem_Req, 1);
    #2 Rst = 1'b0;
    #1;
    checkOutput("rstAcc.req", DMem_Req, 0);
    checkOutput("rstAcc.stall", Stall, 0);
    checkOutput("rstAcc.addr", DMem_Addr, 0);
    Rst = 1'b1;
    DMem_Ack = 1'b1;
    tick();
    DMem_Ack = 1'b0;
    checkOutput("lateAck.wbValid", WB_Valid, 0);
    checkOutput("lateAck.req", DMem_Req, 0);
    tick();

    // Randomized instructions against the reference model
    for (int k = 0; k < 24; k++) begin
      runOp(randInstr(), $urandom_range(0, AckTimeout - 1), $urandom, "rand");
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
